// File: rtl/sdlc_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdlc_rx_ctrl
//  Description : SDLC receive frame controller. Takes the DPLL-recovered bit
//                stream (one bit per bit_valid strobe), delimits frames on
//                7E flags, drops stuffed zeros, detects aborts, assembles
//                bytes LSB-first, checks the CRC-16/X.25 FCS and hands bytes
//                to the CPU side over a single-entry valid/ack handshake.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock (shared with the DPLL)
//    reset_n     in   synchronous active-low reset
//    bit_valid   in   strobe: bit_in carries a new received bit
//    bit_in      in   received bit
//    byte_data   out  assembled byte, first-received bit in bit 0
//    byte_valid  out  byte_data holds an unconsumed byte
//    byte_ack    in   consumer takes byte_data this cycle
//    in_frame    out  at least one byte of the current frame emitted
//    frame_end   out  pulse: closing flag of a frame with >= 1 byte
//    frame_ok    out  qualifies frame_end (good FCS, length, alignment)
//    abort       out  pulse: abort sequence inside a frame
//    overrun     out  pulse: byte dropped because previous one still pending
// ============================================================================
module sdlc_rx_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ack,
    output logic       in_frame,
    output logic       frame_end,
    output logic       frame_ok,
    output logic       abort,
    output logic       overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  c_HUNT      = 2'd0;  // looking for an opening flag
    localparam logic [1:0]  c_SYNC      = 2'd1;  // flag seen, no byte yet
    localparam logic [1:0]  c_DATA      = 2'd2;  // inside a frame with bytes

    localparam logic [15:0] c_CRC_POLY  = 16'h8408;
    localparam logic [15:0] c_CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] c_CRC_GOOD  = 16'hF0B8;
    localparam logic [1:0]  c_MIN_BYTES = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [2:0]  r_ones;       // consecutive ones, saturating at 7
    logic [2:0]  r_bit_cnt;    // data bits already in r_shift
    logic [1:0]  r_byte_cnt;   // bytes in this frame, saturating at 3
    logic [7:0]  r_shift;
    logic [15:0] r_crc;
    logic        r_frame_bad;  // an overrun hit the current frame

    // ------------------------------------------------------------------------
    // Reflected CRC over one byte, least significant bit first
    // ------------------------------------------------------------------------
    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] crc;
        crc = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (crc[0]) crc = (crc >> 1) ^ c_CRC_POLY;
            else        crc = crc >> 1;
        end
        return crc;
    endfunction

    // ------------------------------------------------------------------------
    // Bit classification, always on the pre-update ones count
    // ------------------------------------------------------------------------
    logic        w_is_abort;
    logic        w_is_flag;
    logic        w_is_stuff;
    logic        w_is_data;
    logic [2:0]  w_ones_next;
    logic [7:0]  w_byte;
    logic        w_byte_done;
    logic [15:0] w_crc_next;
    logic        w_can_load;
    logic        w_close_ok;

    assign w_is_abort  =  bit_in && (r_ones == 3'd6);
    assign w_is_flag   = !bit_in && (r_ones == 3'd6);
    assign w_is_stuff  = !bit_in && (r_ones == 3'd5);
    assign w_is_data   = !(w_is_abort || w_is_flag || w_is_stuff);

    assign w_ones_next = !bit_in          ? 3'd0 :
                         (r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1;

    // New bits enter at the MSB so the first-received bit ends up in bit 0.
    assign w_byte      = {bit_in, r_shift[7:1]};
    assign w_byte_done = (r_bit_cnt == 3'd7);
    assign w_crc_next  = f_crc_byte(r_crc, w_byte);

    // The holding register is free if empty or being drained this cycle.
    assign w_can_load  = !byte_valid || byte_ack;

    // A closing flag's first seven bits were shifted in as data, so a
    // byte-aligned frame leaves exactly seven bits in the assembler.
    assign w_close_ok  = (r_bit_cnt == 3'd7)
                      && (r_byte_cnt >= c_MIN_BYTES)
                      && (r_crc == c_CRC_GOOD)
                      && !r_frame_bad;

    // ------------------------------------------------------------------------
    // Frame FSM, assembler, CRC and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_HUNT;
            r_ones      <= 3'd0;
            r_bit_cnt   <= 3'd0;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 8'h00;
            r_crc       <= c_CRC_INIT;
            r_frame_bad <= 1'b0;
            byte_data   <= 8'h00;
            byte_valid  <= 1'b0;
            in_frame    <= 1'b0;
            frame_end   <= 1'b0;
            frame_ok    <= 1'b0;
            abort       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            frame_ok  <= 1'b0;
            abort     <= 1'b0;
            overrun   <= 1'b0;

            // Consumer side; a same-cycle load below takes precedence.
            if (byte_valid && byte_ack) begin
                byte_valid <= 1'b0;
            end

            if (bit_valid) begin
                r_ones <= w_ones_next;

                // Flags and aborts both restart byte assembly and the FCS.
                if (w_is_flag || w_is_abort) begin
                    r_bit_cnt   <= 3'd0;
                    r_byte_cnt  <= 2'd0;
                    r_crc       <= c_CRC_INIT;
                    r_frame_bad <= 1'b0;
                end

                case (r_state)
                    c_HUNT: begin
                        if (w_is_flag) begin
                            r_state <= c_SYNC;
                        end
                    end

                    c_SYNC, c_DATA: begin
                        if (w_is_flag) begin
                            // Closing flag also opens the next frame.
                            if (r_state == c_DATA) begin
                                frame_end <= 1'b1;
                                frame_ok  <= w_close_ok;
                                in_frame  <= 1'b0;
                            end
                            r_state <= c_SYNC;
                        end else if (w_is_abort) begin
                            // Only a frame that has produced bytes reports it.
                            if (r_state == c_DATA) begin
                                abort <= 1'b1;
                            end
                            in_frame <= 1'b0;
                            r_state  <= c_HUNT;
                        end else if (w_is_data) begin
                            r_shift <= w_byte;
                            if (w_byte_done) begin
                                r_bit_cnt <= 3'd0;
                                if (r_byte_cnt != 2'd3) begin
                                    r_byte_cnt <= r_byte_cnt + 2'd1;
                                end
                                // FCS runs over every completed byte, even a
                                // dropped one; the frame is flagged bad instead.
                                r_crc <= w_crc_next;
                                if (w_can_load) begin
                                    byte_data  <= w_byte;
                                    byte_valid <= 1'b1;
                                end else begin
                                    overrun     <= 1'b1;
                                    r_frame_bad <= 1'b1;
                                end
                                in_frame <= 1'b1;
                                r_state  <= c_DATA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                        // Stuffed zeros fall through and are discarded.
                    end

                    default: begin
                        r_state <= c_HUNT;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdlc_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdlc_rx_ctrl
//  Description : Directed self-checking bench for sdlc_rx_ctrl. A single
//                driver process sends bit-stuffed frames, plays the consumer
//                side of the byte handshake and tallies the status pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdlc_rx_ctrl;

    localparam int c_SP = 4;  // clocks per received bit

    logic       clk = 1'b0;
    logic       reset_n;
    logic       bit_valid;
    logic       bit_in;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ack;
    logic       in_frame;
    logic       frame_end;
    logic       frame_ok;
    logic       abort;
    logic       overrun;

    always #5 clk = ~clk;

    sdlc_rx_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ack   (byte_ack),
        .in_frame   (in_frame),
        .frame_end  (frame_end),
        .frame_ok   (frame_ok),
        .abort      (abort),
        .overrun    (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse tallies and snapshots for per-test deltas
    int n_fe = 0, n_ok = 0, n_ab = 0, n_ov = 0, n_stray = 0;
    int s_fe = 0, s_ok = 0, s_ab = 0, s_ov = 0;

    logic [7:0] rx_q[$];
    bit         auto_ack = 1'b1;
    int         vcnt     = 0;
    int         tx_ones  = 0;

    // "123456789" followed by its X.25 FCS, low byte first
    logic [7:0] good [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                              8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: observe registered outputs at the falling edge, then drive
    // the inputs for the next rising edge.
    task automatic tick(input logic v, input logic b, input logic fa);
        logic ack_now;
        @(negedge clk);
        if (frame_end === 1'b1) begin
            n_fe++;
            if (frame_ok === 1'b1) n_ok++;
        end else if (frame_ok === 1'b1) begin
            n_stray++;
        end
        if (abort === 1'b1)   n_ab++;
        if (overrun === 1'b1) n_ov++;
        ack_now = fa || (auto_ack && (byte_valid === 1'b1) && (vcnt >= 1));
        if (ack_now && (byte_valid === 1'b1)) rx_q.push_back(byte_data);
        if ((byte_valid === 1'b1) && !ack_now) vcnt++;
        else                                    vcnt = 0;
        byte_ack  = ack_now;
        bit_valid = v;
        bit_in    = b;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bit(input logic b, input logic fa);
        tick(1'b1, b, fa);
        idle(c_SP - 1);
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i], 1'b0);
        tx_ones = 0;
    endtask

    // Data byte LSB-first with zero insertion after five ones
    task automatic send_byte(input logic [7:0] d, input logic fa_last);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], fa_last && (i == 7));
            if (d[i]) tx_ones++;
            else      tx_ones = 0;
            if (tx_ones == 5) begin
                send_bit(1'b0, 1'b0);
                tx_ones = 0;
            end
        end
    endtask

    task automatic send_good();
        for (int i = 0; i < 11; i++) send_byte(good[i], 1'b0);
    endtask

    task automatic snap();
        s_fe = n_fe; s_ok = n_ok; s_ab = n_ab; s_ov = n_ov;
        rx_q.delete();
    endtask

    task automatic check_good_bytes(input string tag);
        check_eq({tag, "_count"}, rx_q.size(), 11);
        for (int i = 0; i < 11; i++)
            check_eq($sformatf("%s_b%0d", tag, i), rx_q[i], good[i]);
    endtask

    // Independent serial form of the X.25 CRC, used only to build stimulus
    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 16'h8408;
        end
        return r;
    endfunction

    initial begin
        logic [15:0] crc;
        logic [15:0] fcs;
        logic [7:0]  bad;

        reset_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; byte_ack = 1'b0;
        idle(3);
        check_eq("reset_outputs",
                 {byte_data, byte_valid, in_frame, frame_end, frame_ok, abort, overrun},
                 14'h0000);
        reset_n = 1'b1;
        idle(2);

        // Ones in HUNT (one of them forms an abort) then a flag: silent
        snap();
        repeat (16) send_bit(1'b1, 1'b0);
        send_flag();
        check_eq("hunt_no_byte",  byte_valid, 1'b0);
        check_eq("hunt_no_abort", n_ab - s_ab, 0);
        check_eq("hunt_in_frame", in_frame, 1'b0);

        // Good frame opened by that flag
        snap();
        send_byte(good[0], 1'b0);
        check_eq("good_in_frame_mid", in_frame, 1'b1);
        for (int i = 1; i < 11; i++) send_byte(good[i], 1'b0);
        send_flag();
        idle(2);
        check_good_bytes("good");
        check_eq("good_fe", n_fe - s_fe, 1);
        check_eq("good_ok", n_ok - s_ok, 1);
        check_eq("good_in_frame_after", in_frame, 1'b0);

        // Bit 3 of 0x35 inverted: FCS must fail
        snap();
        bad = good[4] ^ 8'h08;
        for (int i = 0; i < 11; i++) send_byte((i == 4) ? bad : good[i], 1'b0);
        send_flag();
        idle(2);
        check_eq("crcerr_count", rx_q.size(), 11);
        check_eq("crcerr_b4", rx_q[4], 8'h3D);
        check_eq("crcerr_fe", n_fe - s_fe, 1);
        check_eq("crcerr_ok", n_ok - s_ok, 0);

        // Payload needing zero insertion, with a correct FCS
        snap();
        crc = 16'hFFFF;
        crc = crc_step(crc, 8'hFF);
        crc = crc_step(crc, 8'h7E);
        crc = crc_step(crc, 8'h1F);
        fcs = ~crc;
        send_byte(8'hFF, 1'b0);
        send_byte(8'h7E, 1'b0);
        send_byte(8'h1F, 1'b0);
        send_byte(fcs[7:0], 1'b0);
        send_byte(fcs[15:8], 1'b0);
        send_flag();
        idle(2);
        check_eq("stuff_count", rx_q.size(), 5);
        check_eq("stuff_b0", rx_q[0], 8'hFF);
        check_eq("stuff_b1", rx_q[1], 8'h7E);
        check_eq("stuff_b2", rx_q[2], 8'h1F);
        check_eq("stuff_ok", n_ok - s_ok, 1);

        // Abort after two bytes, then recovery on the next flag
        snap();
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        repeat (7) send_bit(1'b1, 1'b0);
        tx_ones = 0;
        idle(2);
        check_eq("abort_pulse", n_ab - s_ab, 1);
        check_eq("abort_no_fe", n_fe - s_fe, 0);
        check_eq("abort_in_frame", in_frame, 1'b0);
        check_eq("abort_count", rx_q.size(), 2);
        snap();
        send_flag();
        send_good();
        send_flag();
        idle(2);
        check_eq("recover_ok", n_ok - s_ok, 1);
        check_eq("recover_ab", n_ab - s_ab, 0);

        // No acks: first byte held, the other ten overrun, frame bad
        snap();
        auto_ack = 1'b0;
        send_good();
        send_flag();
        idle(2);
        check_eq("ovr_pulses", n_ov - s_ov, 10);
        check_eq("ovr_fe", n_fe - s_fe, 1);
        check_eq("ovr_ok", n_ok - s_ok, 0);
        check_eq("ovr_held_valid", byte_valid, 1'b1);
        check_eq("ovr_held_data", byte_data, 8'h31);

        // Ack in the completing cycle frees the slot: no overrun
        snap();
        send_byte(8'h41, 1'b1);
        check_eq("sameack_no_ovr", n_ov - s_ov, 0);
        check_eq("sameack_taken", rx_q.size(), 1);
        check_eq("sameack_old", rx_q[0], 8'h31);
        check_eq("sameack_valid", byte_valid, 1'b1);
        check_eq("sameack_data", byte_data, 8'h41);
        auto_ack = 1'b1;
        idle(4);
        send_flag();
        idle(2);

        // Four extra bits before the flag: a stray byte forms, frame misaligned
        snap();
        send_good();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_flag();
        idle(2);
        check_eq("align_count", rx_q.size(), 12);
        check_eq("align_stray", rx_q[11], 8'hE5);
        check_eq("align_fe", n_fe - s_fe, 1);
        check_eq("align_ok", n_ok - s_ok, 0);

        // Two good frames separated by shared-zero flags
        snap();
        send_good();
        send_bit(1'b0, 1'b0);
        repeat (6) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        repeat (6) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        tx_ones = 0;
        send_good();
        send_flag();
        idle(2);
        check_eq("shared_fe", n_fe - s_fe, 2);
        check_eq("shared_ok", n_ok - s_ok, 2);
        check_eq("shared_count", rx_q.size(), 22);

        // Reset in the middle of a frame: silent discard, then a clean frame
        snap();
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        reset_n = 1'b0;
        idle(3);
        check_eq("midrst_outputs",
                 {byte_data, byte_valid, in_frame, frame_end, frame_ok, abort, overrun},
                 14'h0000);
        check_eq("midrst_no_fe", n_fe - s_fe, 0);
        check_eq("midrst_no_ab", n_ab - s_ab, 0);
        reset_n = 1'b1;
        tx_ones = 0;
        idle(2);
        snap();
        send_flag();
        send_good();
        send_flag();
        idle(2);
        check_good_bytes("postrst");
        check_eq("postrst_ok", n_ok - s_ok, 1);

        check_eq("frame_ok_qualified", n_stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
